byte_striping_param: RTL and testbench
======================================

Name: byte_striping_param

Overview:
Parametrised successor to the fixed 4-lane byte striper. Runs in a single clock domain. Accepts a serial byte stream over a valid/ready handshake and distributes bytes round-robin across a runtime-selectable number of lanes. Presents each completed group in parallel on all lanes with a group valid/ready handshake; sits between the serial byte source and the per-lane encoders.

Parameters:
NUM_LANES, 4, total lanes; power of two, >=2
BYTE_W, 8, bits per lane symbol
FLUSH_TIMEOUT, 8, idle cycles before a partial group is flushed (used only with the optional feature)
CNT_W (localparam), $clog2(NUM_LANES), width of the fill counter
MODE_W (localparam), $clog2($clog2(NUM_LANES)+1), width of lane_mode

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_data  in  BYTE_W  serial input byte
in_vld  in  1  in_data valid
in_rdy  out  1  block can accept a byte this cycle
lane_mode  in  MODE_W  active lanes = 1<<lane_mode; values above log2(NUM_LANES) clamp to NUM_LANES
lanes_data  out  NUM_LANES*BYTE_W  lane i occupies bits [i*BYTE_W +: BYTE_W]
lanes_vld  out  NUM_LANES  per-lane valid of the presented group
grp_vld  out  1  group register holds a group
grp_rdy  in  1  downstream consumes the group
counter  out  CNT_W  next lane index to fill (current fill count)

Behaviour:
- Reset (reset=0, async): counter=0; grp_vld=0; lanes_vld=0; lanes_data=0; accumulator=0; latched active count = NUM_LANES; idle timer=0.
- Byte accepted when in_vld && in_rdy. The byte is written to accumulator[counter] and counter increments.
- The active lane count n_act is latched from lane_mode only when counter==0 and a byte is accepted. A mode change mid-group is ignored until the next group.
- Last byte (counter==n_act-1) accepted:
  - next edge: lanes_data = accumulator with the new byte in lane n_act-1;
  - lanes_vld[i] = (i < n_act); lanes i >= n_act are driven 0;
  - grp_vld=1; counter wraps to 0.
  - Latency from last byte to grp_vld is 1 cycle.
- in_rdy = (counter != n_act-1) || !grp_vld || grp_rdy. This is combinational; only the group-completing byte is back-pressured.
- Group handshake: the group is consumed on grp_vld && grp_rdy. grp_vld drops next edge unless a new group loads in the same edge; a simultaneous consume and load keeps grp_vld=1 with the new data.
- lanes_data/lanes_vld hold stable while grp_vld && !grp_rdy.
- n_act=1: every accepted byte forms a group. Throughput is 1 byte/cycle with grp_rdy held high.
- States: IDLE (counter==0, no partial group); FILL (0<counter<n_act).
  - IDLE->FILL on an accepted byte when n_act>1.
  - FILL->IDLE on the group-completing byte.
  - IDLE->IDLE with a group emitted when n_act=1.
- Reset asserted mid-group: the partial group and the pending group are discarded; no output glitch beyond the async clear.

Optional Feature:
BYTE_STRIPING_FLUSH_EN.
- Defined:
  - In FILL, an idle timer counts cycles with no accepted byte; it resets on each accept.
  - When the timer reaches FLUSH_TIMEOUT and the group register is free (or grp_rdy=1), the partial group is emitted with lanes_vld[i]=(i<counter), unfilled lanes driven 0, counter=0.
  - If the group register is busy, the flush waits.
- Undefined: no timer; a partial group is held indefinitely until completed.

Decomposition:
- Shared package byte_striping_pkg: BYTE_W default, lane-mode encoding constants (MODE_1LANE=0, MODE_2LANE=1, MODE_4LANE=2, ...), and a clog2-based helper function for n_act decode.
- One natural sub-module: striping_group_reg, the parallel output register with the valid/ready hold logic, instantiated once.
- Accumulator, counter and FSM live in the top module.

Test Plan:
- NUM_LANES=4, lane_mode=2, grp_rdy=1, in bytes 0x10..0x17 back-to-back -> two groups: lanes {0x10,0x11,0x12,0x13} then {0x14,...,0x17}; lanes_vld=4'hF; grp_vld pulses one cycle after 0x13 and after 0x17; counter sequence 0,1,2,3,0.
- lane_mode=1, bytes 0xA0..0xA3 -> groups {0xA0,0xA1} and {0xA2,0xA3}; lanes_vld=4'b0011; lanes 2,3 = 0x00.
- Backpressure: grp_rdy=0 after the first group, stream 0x00..0x07 -> in_rdy falls when counter==3 with a group pending; the first group holds stable; on grp_rdy=1 the second group {0x04..0x07} loads in the same edge as the consume, grp_vld stays 1.
- Mode change mid-group: lane_mode 2->0 after 2 bytes -> the current group still completes at 4 bytes; the next byte forms a 1-lane group with lanes_vld=4'b0001.
- Async reset asserted with counter=2 and grp_vld=1 -> all outputs 0 immediately; after release, the first 4 bytes form a clean group.
- With BYTE_STRIPING_FLUSH_EN, FLUSH_TIMEOUT=8, send 0x55,0x66 then idle -> group emitted after 8 idle cycles with lanes_vld=4'b0011, lanes {0x55,0x66,0,0}. Without the macro -> no group is emitted.

Source files
------------

// File: rtl/byte_striping_pkg.sv
// rtl/byte_striping_pkg.sv - shared types, lane-mode encodings and decode helper for the byte striper
package byte_striping_pkg;

    localparam int BYTE_W_DEFAULT = 8;

    // lane_mode encodings: active lanes = 1 << lane_mode
    localparam int MODE_1LANE = 0;
    localparam int MODE_2LANE = 1;
    localparam int MODE_4LANE = 2;
    localparam int MODE_8LANE = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } stripe_state_e;

    // Decode lane_mode to an active lane count, clamping modes above max_log2.
    function automatic int unsigned mode_to_lanes(input int unsigned mode,
                                                  input int unsigned max_log2);
        int unsigned m;
        m = (mode > max_log2) ? max_log2 : mode;
        return 32'd1 << m;
    endfunction

endpackage

// File: rtl/byte_striping_param_group_reg.sv
// rtl/byte_striping_param_group_reg.sv - parallel group output register with valid/ready hold
// Ports: clk, reset (async active-low), load_i/load_data_i/load_vld_i (new group),
//        grp_rdy_i (downstream consume), lanes_data_o/lanes_vld_o/grp_vld_o (presented group).
module striping_group_reg #(
    parameter int NUM_LANES = 4,
    parameter int BYTE_W    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_i,
    input  logic [NUM_LANES*BYTE_W-1:0] load_data_i,
    input  logic [NUM_LANES-1:0]        load_vld_i,
    input  logic                        grp_rdy_i,
    output logic [NUM_LANES*BYTE_W-1:0] lanes_data_o,
    output logic [NUM_LANES-1:0]        lanes_vld_o,
    output logic                        grp_vld_o
);

    logic [NUM_LANES*BYTE_W-1:0] data_q;
    logic [NUM_LANES-1:0]        vld_q;
    logic                        grp_vld_q;

    // The upstream only asserts load_i when the register is free or being
    // consumed this edge, so a load always overrides the consume.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q    <= '0;
            vld_q     <= '0;
            grp_vld_q <= 1'b0;
        end else if (load_i) begin
            data_q    <= load_data_i;
            vld_q     <= load_vld_i;
            grp_vld_q <= 1'b1;
        end else if (grp_vld_q && grp_rdy_i) begin
            vld_q     <= '0;
            grp_vld_q <= 1'b0;
        end
    end

    assign lanes_data_o = data_q;
    assign lanes_vld_o  = vld_q;
    assign grp_vld_o    = grp_vld_q;

endmodule

// File: rtl/byte_striping_param.sv
// rtl/byte_striping_param.sv - round-robin serial-to-parallel byte striper with runtime lane count
// Ports: clk, reset (async active-low), in_data/in_vld/in_rdy (serial bytes), lane_mode (active
//        lanes = 1<<lane_mode, clamped), lanes_data/lanes_vld/grp_vld/grp_rdy (group output),
//        counter (next lane to fill).
// Optional: define BYTE_STRIPING_FLUSH_EN to flush a partial group after FLUSH_TIMEOUT idle cycles.
module byte_striping_param
    import byte_striping_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int BYTE_W        = BYTE_W_DEFAULT,
    parameter int FLUSH_TIMEOUT = 8,
    localparam int CNT_W        = $clog2(NUM_LANES),
    localparam int MODE_W       = $clog2($clog2(NUM_LANES) + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BYTE_W-1:0]           in_data,
    input  logic                        in_vld,
    output logic                        in_rdy,
    input  logic [MODE_W-1:0]           lane_mode,
    output logic [NUM_LANES*BYTE_W-1:0] lanes_data,
    output logic [NUM_LANES-1:0]        lanes_vld,
    output logic                        grp_vld,
    input  logic                        grp_rdy,
    output logic [CNT_W-1:0]            counter
);

    stripe_state_e                      state_q, state_d;
    logic [CNT_W-1:0]                   counter_q, counter_d;
    logic [CNT_W:0]                     n_act_q, n_act_d, n_eff;
    logic [NUM_LANES-1:0][BYTE_W-1:0]   acc_q, acc_d;
    logic [NUM_LANES-1:0][BYTE_W-1:0]   load_data;
    logic [NUM_LANES-1:0]               load_vld;
    logic                               last_slot, accept, complete, flush_fire, load;

    // At the start of a group the lane count comes straight from lane_mode so
    // that the first byte of a 1-lane group is already treated as the last one.
    assign n_eff     = (counter_q == '0)
                     ? (CNT_W+1)'(mode_to_lanes(32'(lane_mode), CNT_W))
                     : n_act_q;
    assign last_slot = ({1'b0, counter_q} == (n_eff - 1'b1));
    assign in_rdy    = !last_slot || !grp_vld || grp_rdy;
    assign accept    = in_vld && in_rdy;
    assign complete  = accept && last_slot;
    assign load      = complete || flush_fire;

`ifdef BYTE_STRIPING_FLUSH_EN
    localparam int TMR_W = $clog2(FLUSH_TIMEOUT + 1);
    logic [TMR_W-1:0] timer_q, timer_d;

    assign flush_fire = (state_q == ST_FILL) && !accept
                     && (timer_q == TMR_W'(FLUSH_TIMEOUT)) && (!grp_vld || grp_rdy);

    always_comb begin
        timer_d = timer_q;
        if (state_q != ST_FILL || accept || flush_fire) begin
            timer_d = '0;
        end else if (timer_q != TMR_W'(FLUSH_TIMEOUT)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign flush_fire = 1'b0;
`endif

    always_comb begin
        acc_d     = acc_q;
        n_act_d   = n_act_q;
        counter_d = counter_q;
        load_data = '0;
        load_vld  = '0;
        if (accept) begin
            acc_d[counter_q] = in_data;
            counter_d        = counter_q + 1'b1;
            if (counter_q == '0) begin
                n_act_d = n_eff;
            end
        end
        if (load) begin
            counter_d = '0;
        end
        // Lanes beyond the fill point may hold stale bytes from earlier groups.
        for (int i = 0; i < NUM_LANES; i++) begin
            load_vld[i]  = complete ? ((CNT_W+1)'(i) < n_eff)
                                    : ((CNT_W+1)'(i) < {1'b0, counter_q});
            load_data[i] = load_vld[i] ? acc_d[i] : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && !complete) state_d = ST_FILL;
            ST_FILL: if (load)                state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            n_act_q   <= (CNT_W+1)'(NUM_LANES);
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            n_act_q   <= n_act_d;
            acc_q     <= acc_d;
        end
    end

    assign counter = counter_q;

    striping_group_reg #(
        .NUM_LANES (NUM_LANES),
        .BYTE_W    (BYTE_W)
    ) u_group_reg (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load),
        .load_data_i  (load_data),
        .load_vld_i   (load_vld),
        .grp_rdy_i    (grp_rdy),
        .lanes_data_o (lanes_data),
        .lanes_vld_o  (lanes_vld),
        .grp_vld_o    (grp_vld)
    );

endmodule

// File: tb/tb_byte_striping_param.sv
// tb/tb_byte_striping_param.sv - directed self-checking bench for byte_striping_param
module tb_byte_striping_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_vld;
    logic        in_rdy;
    logic [1:0]  lane_mode;
    logic [31:0] lanes_data;
    logic [3:0]  lanes_vld;
    logic        grp_vld;
    logic        grp_rdy;
    logic [1:0]  counter;

    int total = 0;
    int fails = 0;
    logic seen;

    always #5 clk = ~clk;

    byte_striping_param #(
        .NUM_LANES     (4),
        .BYTE_W        (8),
        .FLUSH_TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .lane_mode  (lane_mode),
        .lanes_data (lanes_data),
        .lanes_vld  (lanes_vld),
        .grp_vld    (grp_vld),
        .grp_rdy    (grp_rdy),
        .counter    (counter)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        in_data = b;
        in_vld  = 1'b1;
        tick();
    endtask

    initial begin
        reset     = 1'b0;
        in_data   = '0;
        in_vld    = 1'b0;
        lane_mode = 2'd2;
        grp_rdy   = 1'b1;
        #12;
        chk("rst_counter", counter, 0);
        chk("rst_grp_vld", grp_vld, 0);
        chk("rst_lanes_vld", lanes_vld, 0);
        chk("rst_lanes_data", lanes_data, 0);
        reset = 1'b1;
        tick();

        // Four lanes, back-to-back bytes 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(8'h10 + i);
            in_vld  = 1'b1;
            #1;
            chk("ctr_seq", counter, i % 4);
            tick();
            chk("grp_pulse", grp_vld, (i % 4 == 3) ? 1 : 0);
            if (i == 3) begin
                chk("g4a_data", lanes_data, 32'h13121110);
                chk("g4a_vld", lanes_vld, 4'hF);
            end
            if (i == 7) begin
                chk("g4b_data", lanes_data, 32'h17161514);
                chk("g4b_vld", lanes_vld, 4'hF);
                chk("g4b_ctr", counter, 0);
            end
        end

        // Two lanes
        lane_mode = 2'd1;
        send(8'hA0);
        send(8'hA1);
        chk("g2a_vld", grp_vld, 1);
        chk("g2a_data", lanes_data, 32'h0000A1A0);
        chk("g2a_lvld", lanes_vld, 4'b0011);
        send(8'hA2);
        chk("g2_gap", grp_vld, 0);
        send(8'hA3);
        chk("g2b_data", lanes_data, 32'h0000A3A2);
        chk("g2b_lvld", lanes_vld, 4'b0011);

        // Backpressure
        lane_mode = 2'd2;
        for (int i = 0; i < 4; i++) send(8'(i));
        chk("bp_g1_vld", grp_vld, 1);
        grp_rdy = 1'b0;
        for (int i = 4; i < 7; i++) send(8'(i));
        chk("bp_ctr3", counter, 3);
        in_data = 8'h07;
        #1;
        chk("bp_rdy_low", in_rdy, 0);
        tick();
        chk("bp_hold_vld", grp_vld, 1);
        chk("bp_hold_data", lanes_data, 32'h03020100);
        chk("bp_hold_ctr", counter, 3);
        tick();
        chk("bp_hold_data2", lanes_data, 32'h03020100);
        grp_rdy = 1'b1;
        #1;
        chk("bp_rdy_high", in_rdy, 1);
        tick();
        chk("bp_swap_vld", grp_vld, 1);
        chk("bp_swap_data", lanes_data, 32'h07060504);
        chk("bp_swap_ctr", counter, 0);
        in_vld = 1'b0;
        tick();
        chk("bp_drain", grp_vld, 0);

        // Mode change mid-group
        lane_mode = 2'd2;
        send(8'h20);
        send(8'h21);
        lane_mode = 2'd0;
        send(8'h22);
        send(8'h23);
        chk("mc_g4_data", lanes_data, 32'h23222120);
        chk("mc_g4_vld", lanes_vld, 4'hF);
        send(8'h24);
        chk("mc_g1_grp", grp_vld, 1);
        chk("mc_g1_data", lanes_data, 32'h00000024);
        chk("mc_g1_vld", lanes_vld, 4'b0001);
        in_vld = 1'b0;
        tick();

        // Async reset mid-group with a pending group
        lane_mode = 2'd2;
        grp_rdy   = 1'b0;
        for (int i = 0; i < 6; i++) send(8'(8'h30 + i));
        in_vld = 1'b0;
        chk("ar_pre_ctr", counter, 2);
        chk("ar_pre_grp", grp_vld, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_counter", counter, 0);
        chk("ar_grp_vld", grp_vld, 0);
        chk("ar_lanes_vld", lanes_vld, 0);
        chk("ar_lanes_data", lanes_data, 0);
        #2;
        reset   = 1'b1;
        grp_rdy = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send(8'(8'h40 + i));
        chk("ar_clean_data", lanes_data, 32'h43424140);
        chk("ar_clean_vld", lanes_vld, 4'hF);

        // Partial group then idle
        send(8'h55);
        send(8'h66);
        in_vld = 1'b0;
        seen   = 1'b0;
`ifdef BYTE_STRIPING_FLUSH_EN
        for (int k = 0; k < 12 && !seen; k++) begin
            tick();
            seen = grp_vld;
        end
        chk("fl_emitted", seen, 1);
        chk("fl_lvld", lanes_vld, 4'b0011);
        chk("fl_data", lanes_data, 32'h00006655);
        chk("fl_ctr", counter, 0);
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            seen = seen | grp_vld;
        end
        chk("nofl_grp", seen, 0);
        chk("nofl_ctr", counter, 2);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
